// File: rtl/beat_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// beat_seq_pkg
// Shared definitions for the beat sequencer and the downstream tone ROM:
//   - BEAT_W      : width of the beat index bus (shared with the tone ROM)
//   - seq_state_e : playback FSM states (IDLE, PLAY, PAUSE)
//   - TEMPO_*     : tempo_sel codes
//   - tempo_period: clocks per beat for a tempo code
// -----------------------------------------------------------------------------
package beat_seq_pkg;

  localparam int unsigned BEAT_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } seq_state_e;

  localparam logic [1:0] TEMPO_4HZ  = 2'd0;
  localparam logic [1:0] TEMPO_8HZ  = 2'd1;
  localparam logic [1:0] TEMPO_16HZ = 2'd2;
  localparam logic [1:0] TEMPO_2HZ  = 2'd3;

  // Clocks per beat for a tempo code (integer division of the clock rate).
  function automatic int unsigned tempo_period(input logic [1:0] sel,
                                               input int unsigned clk_hz);
    case (sel)
      TEMPO_4HZ:  return clk_hz / 32'd4;
      TEMPO_8HZ:  return clk_hz / 32'd8;
      TEMPO_16HZ: return clk_hz / 32'd16;
      TEMPO_2HZ:  return clk_hz / 32'd2;
      default:    return clk_hz / 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// -----------------------------------------------------------------------------
// beat_sequencer_if
// Command/status bundle between the playback controller and its user.
//   Commands (master -> slave): play, pause, stop (1-cycle pulses),
//     loop_en (level), tempo_sel[1:0], and with BEAT_SEQ_SEEK_EN defined
//     seek_fwd / seek_back (1-cycle pulses).
//   Status (slave -> master): ibeatNum[11:0], en, playing, beat_tick, done.
// Optional feature macro: BEAT_SEQ_SEEK_EN.
// -----------------------------------------------------------------------------
interface beat_sequencer_if;
  import beat_seq_pkg::*;

  logic              play;
  logic              pause;
  logic              stop;
  logic              loop_en;
  logic [1:0]        tempo_sel;
  logic [BEAT_W-1:0] ibeatNum;
  logic              en;
  logic              playing;
  logic              beat_tick;
  logic              done;
`ifdef BEAT_SEQ_SEEK_EN
  logic              seek_fwd;
  logic              seek_back;

  modport master (output play, pause, stop, loop_en, tempo_sel, seek_fwd, seek_back,
                  input  ibeatNum, en, playing, beat_tick, done);
  modport slave  (input  play, pause, stop, loop_en, tempo_sel, seek_fwd, seek_back,
                  output ibeatNum, en, playing, beat_tick, done);
`else
  modport master (output play, pause, stop, loop_en, tempo_sel,
                  input  ibeatNum, en, playing, beat_tick, done);
  modport slave  (input  play, pause, stop, loop_en, tempo_sel,
                  output ibeatNum, en, playing, beat_tick, done);
`endif

endinterface

// File: rtl/beat_sequencer_tempo_prescaler.sv
// -----------------------------------------------------------------------------
// tempo_prescaler
// Beat-rate prescaler. Counts 0..period_m1_i and wraps.
//   clk, rst      : system clock, synchronous active-low reset
//   clear_i       : force the count to 0 (highest priority)
//   hold_i        : freeze the count
//   period_m1_i   : latched beat period minus one (terminal count value)
//   tc_o          : count is at terminal; the parent acts on it only in
//                   cycles where it is neither clearing nor holding
// -----------------------------------------------------------------------------
module tempo_prescaler #(
  parameter int unsigned W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         hold_i,
  input  logic [W-1:0] period_m1_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // >= rather than == so a count stranded above the terminal still wraps.
  assign tc_o = (count_q >= period_m1_i);

  // Next count: clear beats hold beats wrap beats increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (hold_i) begin
      count_d = count_q;
    end else if (tc_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
// Playback controller upstream of the tone ROM: produces the beat index and
// playback enable, handles play/pause/stop, tempo selection and loop-at-end.
//   clk        : system clock
//   rst        : synchronous active-low reset
//   bus        : beat_sequencer_if.slave (commands in, registered status out)
// Parameters: CLK_HZ (clock rate), LAST_BEAT (final beat index, <= 4095).
// Optional feature macro: BEAT_SEQ_SEEK_EN adds seek_fwd/seek_back (+/-4 beats).
// The prescaler stores PERIOD-1 so a full PERIOD of CLK_HZ/2 fits its width.
// -----------------------------------------------------------------------------
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned LAST_BEAT = 63
) (
  input  logic             clk,
  input  logic             rst,
  beat_sequencer_if.slave  bus
);

  localparam int unsigned       PRESC_W       = $clog2(CLK_HZ / 32'd2);
  localparam logic [PRESC_W-1:0] PERIOD_RST_M1 = PRESC_W'(CLK_HZ / 32'd4 - 32'd1);
  localparam logic [BEAT_W-1:0]  LAST_B        = BEAT_W'(LAST_BEAT);

  // Terminal count for a tempo code.
  function automatic logic [PRESC_W-1:0] period_m1_of(input logic [1:0] sel);
    return PRESC_W'(tempo_period(sel, CLK_HZ) - 32'd1);
  endfunction

  seq_state_e          state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;
  logic                en_q, en_d;
  logic                playing_q, playing_d;
  logic [PRESC_W-1:0]  period_m1_q, period_m1_d;
  logic                presc_clear_s;
  logic                presc_hold_s;
  logic                presc_tc_s;
  logic                cmd_any_s;
  logic                seek_req_s;
  logic [BEAT_W-1:0]   seek_beat_s;

  tempo_prescaler #(.W(PRESC_W)) u_presc (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (presc_clear_s),
    .hold_i      (presc_hold_s),
    .period_m1_i (period_m1_q),
    .tc_o        (presc_tc_s)
  );

  // Seek only acts when no transport command is present this cycle.
  assign cmd_any_s = bus.stop | bus.pause | bus.play;

`ifdef BEAT_SEQ_SEEK_EN
  assign seek_req_s  = !cmd_any_s && (bus.seek_fwd ^ bus.seek_back);
  assign seek_beat_s = bus.seek_fwd
                       ? (((LAST_B - beat_q) <= 12'd3) ? LAST_B : (beat_q + 12'd4))
                       : ((beat_q < 12'd4) ? 12'd0 : (beat_q - 12'd4));
`else
  assign seek_req_s  = 1'b0;
  assign seek_beat_s = '0;
`endif

  // Next-state, beat position, prescaler control and output decode.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tick_d        = 1'b0;
    done_d        = 1'b0;
    period_m1_d   = period_m1_q;
    presc_clear_s = 1'b0;
    presc_hold_s  = 1'b0;

    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (bus.stop || bus.pause) begin
          presc_clear_s = 1'b1;
        end else if (bus.play) begin
          // The prescaler counts during the play cycle, so the first
          // tick lands PERIOD cycles after play.
          state_d     = PLAY;
          period_m1_d = period_m1_of(bus.tempo_sel);
        end else begin
          presc_clear_s = 1'b1;
        end
      end

      PLAY: begin
        if (bus.stop) begin
          state_d       = IDLE;
          beat_d        = '0;
          presc_clear_s = 1'b1;
        end else if (bus.pause) begin
          state_d      = PAUSE;
          presc_hold_s = 1'b1;
        end else if (seek_req_s) begin
          beat_d        = seek_beat_s;
          presc_clear_s = 1'b1;
        end else if (presc_tc_s) begin
          tick_d      = 1'b1;
          period_m1_d = period_m1_of(bus.tempo_sel);
          if (beat_q < LAST_B) begin
            beat_d = beat_q + 12'd1;
          end else if (bus.loop_en) begin
            beat_d = '0;
          end else begin
            beat_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          beat_d = beat_q;
        end
      end

      PAUSE: begin
        if (bus.stop) begin
          state_d       = IDLE;
          beat_d        = '0;
          presc_clear_s = 1'b1;
        end else if (bus.pause) begin
          presc_hold_s = 1'b1;
        end else if (bus.play) begin
          // Resume counting this cycle from the held value.
          state_d = PLAY;
        end else if (seek_req_s) begin
          beat_d        = seek_beat_s;
          presc_clear_s = 1'b1;
        end else begin
          presc_hold_s = 1'b1;
        end
      end

      default: begin
        state_d       = IDLE;
        beat_d        = '0;
        presc_clear_s = 1'b1;
      end
    endcase

    en_d      = (state_d != IDLE);
    playing_d = (state_d == PLAY);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      playing_q   <= 1'b0;
      period_m1_q <= PERIOD_RST_M1;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      en_q        <= en_d;
      playing_q   <= playing_d;
      period_m1_q <= period_m1_d;
    end
  end

  assign bus.ibeatNum  = beat_q;
  assign bus.en        = en_q;
  assign bus.playing   = playing_q;
  assign bus.beat_tick = tick_q;
  assign bus.done      = done_q;

endmodule
